// File: rtl/dlat_delay_checker.sv
// Receiving-end checker for delayed-latch stages: models D delayed by DELAY
// enabled edges and compares it with the observed Q.
module dlat_delay_checker #(
    parameter int DELAY = 2,
    parameter int ERRW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            d_in,
    input  logic            q_obs,
    output logic            q_exp,
    output logic            valid,
    output logic            mismatch,
    output logic [ERRW-1:0] err_cnt,
    output logic            fail
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      fill_reg, fill_next;
    logic [DELAY-1:0] line_reg;
    logic            mismatch_reg;
    logic [ERRW-1:0] err_reg;
    logic            fail_reg;
    logic            cmp_fail;

    // Delay line: stage 0 is the head, stage DELAY-1 the tail seen as q_exp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_reg[0] <= 1'b0;
        end else if (en) begin
            line_reg[0] <= d_in;
        end
    end

    for (genvar gi = 1; gi < DELAY; gi++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                line_reg[gi] <= 1'b0;
            end else if (en) begin
                line_reg[gi] <= line_reg[gi-1];
            end
        end
    end

    // FILL spans DELAY enabled edges so the tail holds fresh data on entry to CHECK.
    always_comb begin
        state_next = state_reg;
        fill_next  = fill_reg;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next = FILL;
                    fill_next  = 4'd0;
                end
            end
            FILL: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (fill_reg == 4'(DELAY - 1)) begin
                    state_next = CHECK;
                end else begin
                    fill_next = fill_reg + 4'd1;
                end
            end
            CHECK: begin
                if (!en) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                fill_next  = 4'd0;
            end
        endcase
    end

    // The compare still happens on the edge that leaves CHECK.
    assign cmp_fail = (state_reg == CHECK) && (q_obs != line_reg[DELAY-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            fill_reg     <= 4'd0;
            mismatch_reg <= 1'b0;
            err_reg      <= '0;
            fail_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fill_reg     <= fill_next;
            mismatch_reg <= cmp_fail;
            if (cmp_fail) begin
                fail_reg <= 1'b1;
                if (err_reg != '1) begin
                    err_reg <= err_reg + 1'b1;
                end
            end
        end
    end

    assign q_exp    = line_reg[DELAY-1];
    assign valid    = (state_reg == CHECK);
    assign mismatch = mismatch_reg;
    assign err_cnt  = err_reg;
    assign fail     = fail_reg;

endmodule
